half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Bit-parallel half-adder array: for each of LANES lanes, computes sum = a XOR b and carry = a AND b.
- Combinational outputs feed downstream adder trees (e.g. full-adder built from two half adders) with zero latency.
- Registered copies with valid qualification support pipelined datapaths.
- Saturating carry-event counter provides debug/statistics visibility.

Parameters:
- LANES, 1, number of independent 1-bit half-adder lanes (>=1).
- CNT_W, 16, width of the saturating carry-event counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a  in  LANES  addend bit per lane.
- b  in  LANES  addend bit per lane.
- in_valid  in  1  qualifies a/b for the registered path and the counter.
- sum  out  LANES  combinational a XOR b, per lane.
- carry  out  LANES  combinational a AND b, per lane.
- sum_q  out  LANES  registered sum.
- carry_q  out  LANES  registered carry.
- out_valid  out  1  sum_q/carry_q hold a valid result.
- carry_cnt  out  CNT_W  saturating count of lane carries accepted with in_valid.
- clr_cnt  in  1  synchronous clear of carry_cnt.

Behaviour:
- Combinational path: sum[i] = a[i]^b[i], carry[i] = a[i]&b[i]. No clock dependence; valid during reset; independent of in_valid.
- Truth table per lane (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Invariant per lane: {carry[i],sum[i]} equals the 2-bit value a[i]+b[i].
- Registered path:
  - Latency 1 cycle.
  - When in_valid=1 at a rising edge: sum_q<=sum, carry_q<=carry, out_valid<=1.
  - When in_valid=0: sum_q/carry_q hold their values; out_valid<=0.
  - No backpressure; every valid input is accepted.
- Counter:
  - Each edge with in_valid=1 adds popcount(carry) (0..LANES) to carry_cnt.
  - Saturates at 2^CNT_W-1; never wraps.
  - clr_cnt=1 sets carry_cnt to 0 and has priority over a simultaneous increment.
- Reset (rst_n low, asynchronous): sum_q=0, carry_q=0, out_valid=0, carry_cnt=0 immediately, without waiting for a clock edge.
- Reset deassertion is synchronized internally (two-flop) before state updates resume.
- Reset mid-stream: in-flight registered result is discarded; the first valid input after release yields out_valid one cycle later.
- X on a/b with in_valid=0 must not corrupt the counter or registers.

Decomposition:
- Shared package: none required.
- Natural sub-module: ha_cell, a single-lane combinational cell (a, b -> sum, carry), instantiated LANES times via generate.
- Popcount and saturation logic stay in the top.

Test Plan:
- LANES=1, in_valid=0, sweep a,b = 00,01,10,11 at 5 ns steps -> sum/carry = 0/0, 1/0, 1/0, 0/1 immediately after each change.
- in_valid=1 with a=1, b=1 for one cycle -> next edge: carry_q=1, sum_q=0, out_valid=1; following cycle with in_valid=0 -> out_valid=0, sum_q/carry_q hold.
- LANES=4, a=4'b1111, b=4'b1010, in_valid=1 -> sum=4'b0101, carry=4'b1010; carry_cnt increases by 2.
- CNT_W=4, drive a=b=1 with in_valid=1 for 20 cycles -> carry_cnt saturates at 15; assert clr_cnt together with a valid carry input -> carry_cnt=0.
- Assert rst_n=0 mid-cycle while out_valid=1 -> sum_q, carry_q, out_valid, carry_cnt go to 0 before the next edge; sum/carry still follow a/b.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared defaults for the half-adder array and its carry-event counter.
package half_adder_pkg;

  localparam int DEF_LANES = 1;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/half_adder_ha_cell.sv
// Single-lane combinational half adder: {carry, sum} = a + b.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// LANES-wide half-adder array with zero-latency outputs, a valid-qualified
// registered copy and a saturating count of accepted lane carries.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] carry,
  output logic [LANES-1:0] sum_q,
  output logic [LANES-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam int PC_W = $clog2(LANES + 1);

  logic [LANES-1:0] sum_s;
  logic [LANES-1:0] carry_s;
  logic [PC_W-1:0]  pc_s;
  logic [CNT_W:0]   cnt_sum_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [1:0]       rst_sync_r;
  logic [LANES-1:0] sum_q_r;
  logic [LANES-1:0] carry_q_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] cnt_r;

  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] n;
    n = {PC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ha_cell u_cell (
      .a     (a[g]),
      .b     (b[g]),
      .sum   (sum_s[g]),
      .carry (carry_s[g])
    );
  end

  // Counter next value: one extra bit catches overflow and clamps to all-ones.
  always_comb begin
    pc_s      = popcount(carry_s);
    cnt_sum_s = {1'b0, cnt_r} + (CNT_W + 1)'(pc_s);
    if (cnt_sum_s[CNT_W]) begin
      cnt_next_s = {CNT_W{1'b1}};
    end else begin
      cnt_next_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // Reset asserts immediately, releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Registered result path and carry-event counter; held at zero until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q_r     <= {LANES{1'b0}};
      carry_q_r   <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else if (!rst_sync_r[1]) begin
      sum_q_r     <= {LANES{1'b0}};
      carry_q_r   <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      if (in_valid) begin
        sum_q_r     <= sum_s;
        carry_q_r   <= carry_s;
        out_valid_r <= 1'b1;
      end else begin
        sum_q_r     <= sum_q_r;
        carry_q_r   <= carry_q_r;
        out_valid_r <= 1'b0;
      end
      if (clr_cnt) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (in_valid) begin
        cnt_r <= cnt_next_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign sum       = sum_s;
  assign carry     = carry_s;
  assign sum_q     = sum_q_r;
  assign carry_q   = carry_q_r;
  assign out_valid = out_valid_r;
  assign carry_cnt = cnt_r;

endmodule

// File: tb/tb_half_adder.sv
// Directed, table-driven bench for half_adder: a 1-lane/4-bit-counter
// instance and a 4-lane/16-bit-counter instance share clock and reset.
module tb_half_adder;

  logic        clk;
  logic        rst_n;
  logic        a1, b1, v1, clr1;
  logic        sum1, carry1, sum_q1, carry_q1, ov1;
  logic [3:0]  cnt1;
  logic [3:0]  a4, b4, sum4, carry4, sum_q4, carry_q4;
  logic        v4, clr4, ov4;
  logic [15:0] cnt4;

  int checks;
  int failures;

  typedef struct {
    logic a;
    logic b;
    logic sum;
    logic carry;
  } vec1_t;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  sum;
    logic [3:0]  carry;
    logic [15:0] cnt;
  } vec4_t;

  vec1_t tbl1[4];
  vec4_t tbl4[4];

  half_adder #(.LANES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .clr_cnt(clr1),
    .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
    .out_valid(ov1), .carry_cnt(cnt1)
  );

  half_adder #(.LANES(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4), .clr_cnt(clr4),
    .sum(sum4), .carry(carry4), .sum_q(sum_q4), .carry_q(carry_q4),
    .out_valid(ov4), .carry_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tbl1[0] = '{a: 1'b0, b: 1'b0, sum: 1'b0, carry: 1'b0};
    tbl1[1] = '{a: 1'b0, b: 1'b1, sum: 1'b1, carry: 1'b0};
    tbl1[2] = '{a: 1'b1, b: 1'b0, sum: 1'b1, carry: 1'b0};
    tbl1[3] = '{a: 1'b1, b: 1'b1, sum: 1'b0, carry: 1'b1};

    // cnt is the running carry count after each vector is accepted
    tbl4[0] = '{a: 4'b1111, b: 4'b1010, sum: 4'b0101, carry: 4'b1010, cnt: 16'd2};
    tbl4[1] = '{a: 4'b0000, b: 4'b0000, sum: 4'b0000, carry: 4'b0000, cnt: 16'd2};
    tbl4[2] = '{a: 4'b1100, b: 4'b0110, sum: 4'b1010, carry: 4'b0100, cnt: 16'd3};
    tbl4[3] = '{a: 4'b1111, b: 4'b1111, sum: 4'b0000, carry: 4'b1111, cnt: 16'd7};

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; clr1 = 1'b0;
    a4 = 4'b0000; b4 = 4'b0000; v4 = 1'b0; clr4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum_q1", 32'(sum_q1), 32'd0);
    check("reset_carry_q1", 32'(carry_q1), 32'd0);
    check("reset_out_valid1", 32'(ov1), 32'd0);
    check("reset_cnt1", 32'(cnt1), 32'd0);
    check("reset_cnt4", 32'(cnt4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Truth-table sweep, combinational only
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a1 = tbl1[i].a;
      b1 = tbl1[i].b;
      #1;
      check("comb_sum1", 32'(sum1), 32'(tbl1[i].sum));
      check("comb_carry1", 32'(carry1), 32'(tbl1[i].carry));
      #4;
    end
    @(posedge clk);
    #1;
    check("idle_out_valid1", 32'(ov1), 32'd0);
    check("idle_cnt1", 32'(cnt1), 32'd0);

    // One valid 1+1, then an idle cycle with X inputs
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    check("valid_carry_q1", 32'(carry_q1), 32'd1);
    check("valid_sum_q1", 32'(sum_q1), 32'd0);
    check("valid_out_valid1", 32'(ov1), 32'd1);
    check("valid_cnt1", 32'(cnt1), 32'd1);
    @(negedge clk);
    v1 = 1'b0; a1 = 1'bx; b1 = 1'bx;
    @(posedge clk);
    #1;
    check("hold_out_valid1", 32'(ov1), 32'd0);
    check("hold_carry_q1", 32'(carry_q1), 32'd1);
    check("hold_sum_q1", 32'(sum_q1), 32'd0);
    check("hold_cnt1", 32'(cnt1), 32'd1);

    // Saturation at 15, then clear wins over a simultaneous carry
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("sat_cnt1", 32'(cnt1), 32'd15);
    @(negedge clk);
    clr1 = 1'b1;
    @(posedge clk);
    #1;
    check("clr_cnt1", 32'(cnt1), 32'd0);
    check("clr_out_valid1", 32'(ov1), 32'd1);
    @(negedge clk);
    clr1 = 1'b0; v1 = 1'b0;

    // 4-lane vectors through the registered path and counter
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = tbl4[i].a; b4 = tbl4[i].b; v4 = 1'b1;
      #1;
      check("comb_sum4", 32'(sum4), 32'(tbl4[i].sum));
      check("comb_carry4", 32'(carry4), 32'(tbl4[i].carry));
      @(posedge clk);
      #1;
      check("reg_sum_q4", 32'(sum_q4), 32'(tbl4[i].sum));
      check("reg_carry_q4", 32'(carry_q4), 32'(tbl4[i].carry));
      check("reg_out_valid4", 32'(ov4), 32'd1);
      check("reg_cnt4", 32'(cnt4), 32'(tbl4[i].cnt));
    end

    // Asynchronous reset mid-cycle while a valid result is held
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'b1010; v4 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_out_valid4", 32'(ov4), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sum_q4", 32'(sum_q4), 32'd0);
    check("rst_carry_q4", 32'(carry_q4), 32'd0);
    check("rst_out_valid4", 32'(ov4), 32'd0);
    check("rst_cnt4", 32'(cnt4), 32'd0);
    check("rst_comb_sum4", 32'(sum4), 32'h5);
    check("rst_comb_carry4", 32'(carry4), 32'ha);
    a4 = 4'b0011; b4 = 4'b0001;
    #1;
    check("rst_follow_sum4", 32'(sum4), 32'h2);
    check("rst_follow_carry4", 32'(carry4), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("sync_edge1_out_valid4", 32'(ov4), 32'd0);
    @(posedge clk);
    #1;
    check("sync_edge2_out_valid4", 32'(ov4), 32'd0);
    check("sync_edge2_cnt4", 32'(cnt4), 32'd0);
    @(posedge clk);
    #1;
    check("resume_out_valid4", 32'(ov4), 32'd1);
    check("resume_sum_q4", 32'(sum_q4), 32'h2);
    check("resume_carry_q4", 32'(carry_q4), 32'h1);
    check("resume_cnt4", 32'(cnt4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
